// File: rtl/ariane_profiler_pkg.sv
// Shared types and constants for the issue-stall profiler and its snapshot sampler.
package ariane_profiler_pkg;

  localparam int unsigned num_stall_reasons = 35;
  localparam int unsigned seq_max_w         = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_BODY   = 2'd2
  } sampler_state_e;

  // Low 64 bits of the packed struct are the header word at the default width.
  typedef struct packed {
    logic [seq_max_w-1:0] seq;
    logic [15:0]          overrun;
    logic [15:0]          count;
  } header_t;

endpackage

// File: rtl/ariane_profiler_interval_timer.sv
// Free-running sampling-interval timer; advances on enabled cycles and pulses fire_o at the period.
module ariane_profiler_interval_timer #(
  parameter int unsigned interval_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  input  logic [interval_width_p-1:0] interval_i,
  output logic                        fire_o
);

  logic [interval_width_p-1:0] count_q;
  logic                        interval_zero;

  assign interval_zero = (interval_i == '0);

  // >= rather than == so that shrinking the interval fires on the next enabled cycle.
  assign fire_o = en_i & ~interval_zero & (count_q >= (interval_i - 1'b1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (interval_zero) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= fire_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ariane_profiler_sampler.sv
// Atomic snapshot of the stall-counter bank, streamed as a header word plus one word per counter.
module ariane_profiler_sampler
  import ariane_profiler_pkg::*;
#(
  parameter int unsigned width_p          = 64,
  parameter int unsigned num_counters_p   = num_stall_reasons,
  parameter int unsigned interval_width_p = 32
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [interval_width_p-1:0]       interval_i,
  input  logic                              start_i,
  input  logic [num_counters_p*width_p-1:0] counters_i,
  output logic [width_p-1:0]                data_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic                              last_o,
  output logic                              busy_o,
  output logic [15:0]                       overrun_o
);

  // Handshake: a word moves when v_o & ready_i; while v_o & ~ready_i, data_o/last_o hold.
  localparam int unsigned idx_w = $clog2(num_counters_p);
  localparam int unsigned seq_w = width_p - 32;
  localparam logic [idx_w-1:0] last_idx = idx_w'(num_counters_p - 1);

  sampler_state_e     state_q;
  logic [width_p-1:0] shadow_q [num_counters_p];
  logic [idx_w-1:0]   idx_q;
  logic [idx_w-1:0]   idx_nxt;
  logic [seq_w-1:0]   seq_q;
  logic [15:0]        overrun_q;
  logic [width_p-1:0] data_q;
  logic               v_q;
  logic               last_q;

  logic               timer_fire;
  logic               trigger;
  logic               hs;
  logic               final_hs;
  logic               accept;
  header_t            hdr;
  logic [width_p-1:0] header_word;

  ariane_profiler_interval_timer #(
    .interval_width_p(interval_width_p)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .interval_i(interval_i),
    .fire_o    (timer_fire)
  );

  always_comb begin
    trigger     = start_i | timer_fire;
    hs          = v_q & ready_i;
    final_hs    = (state_q == S_BODY) & hs & (idx_q == last_idx);
    accept      = trigger & ((state_q == S_IDLE) | final_hs);
    idx_nxt     = idx_q + 1'b1;
    hdr.seq     = seq_max_w'(seq_q);
    hdr.overrun = overrun_q;
    hdr.count   = 16'(num_counters_p);
    // Truncation keeps {seq[width_p-33:0], overrun, count}; valid for width_p up to 96.
    header_word = width_p'(hdr);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < int'(num_counters_p); k++) begin
        shadow_q[k] <= counters_i[k*width_p +: width_p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      seq_q     <= '0;
      overrun_q <= '0;
      data_q    <= '0;
      v_q       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (trigger & ~accept & (overrun_q != 16'hFFFF)) begin
        overrun_q <= overrun_q + 16'd1;
      end
      if (accept) begin
        seq_q <= seq_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_HEADER;
            data_q  <= header_word;
            v_q     <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        S_HEADER: begin
          if (hs) begin
            state_q <= S_BODY;
            idx_q   <= '0;
            data_q  <= shadow_q[0];
            last_q  <= 1'b0;
          end
        end
        S_BODY: begin
          if (hs) begin
            if (idx_q == last_idx) begin
              last_q <= 1'b0;
              if (accept) begin
                state_q <= S_HEADER;
                data_q  <= header_word;
              end else begin
                state_q <= S_IDLE;
                v_q     <= 1'b0;
                data_q  <= '0;
              end
            end else begin
              idx_q  <= idx_nxt;
              data_q <= shadow_q[idx_nxt];
              last_q <= (idx_nxt == last_idx);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          v_q     <= 1'b0;
          data_q  <= '0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o    = data_q;
  assign v_o       = v_q;
  assign last_o    = last_q;
  assign busy_o    = (state_q != S_IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: doc/ariane_profiler_sampler.md
# ariane_profiler_sampler

Downstream consumer of the CVA6 issue-stall profiler counter bank. Snapshots all stall-reason counters atomically, on a periodic interval or on a host request. Streams the snapshot to the host shell as a header word followed by one word per counter, over a valid/ready interface. Overruns are detected and counted instead of corrupting a snapshot.

## Interface
- width_p, 64, width of each counter and of the output word; must be ≥ 48
- num_counters_p, 35, number of counters in the bank (one per stall reason)
- interval_width_p, 32, width of the sampling-interval register
- clk_i  in  1  clock; all logic on posedge
- reset_i  in  1  synchronous, active-high reset
- en_i  in  1  profiling enable; the interval timer advances only while high
- interval_i  in  interval_width_p  sampling period in enabled cycles; 0 disables periodic sampling
- start_i  in  1  one-cycle host snapshot request
- counters_i  in  num_counters_p*width_p  counter bank; counter k occupies bits [k*width_p +: width_p]
- data_o  out  width_p  stream word
- v_o  out  1  data_o valid
- ready_i  in  1  consumer ready; a word transfers when v_o & ready_i
- last_o  out  1  high with the final word of a snapshot
- busy_o  out  1  snapshot in flight (state ≠ IDLE)
- overrun_o  out  16  saturating count of dropped triggers

## Operation
- Trigger = start_i | timer_fire.
- timer_fire: the timer increments only on en_i. It fires when en_i & interval_i ≠ 0 & count ≥ interval_i−1, and count then returns to 0. The ≥ compare makes a shrunk interval fire on the next enabled cycle. When interval_i = 0, count is held at 0.
- FSM states: IDLE, HEADER, BODY.
- IDLE → HEADER on trigger. On the same edge: shadow ← counters_i, and the header fields are latched.
- HEADER → BODY on handshake; idx ← 0.
- BODY: word = shadow[idx]. idx increments on each handshake. The handshake at idx = num_counters_p−1 asserts last_o and leaves BODY.
  - If a trigger coincides with that final handshake: go straight to HEADER with a new capture.
  - Otherwise: go to IDLE.
- A trigger in HEADER, or in BODY other than on the final handshake, is dropped. overrun_o increments, saturating at 16'hFFFF.
- start_i and timer_fire in the same cycle count as one trigger.
- Header word:
  - [15:0] = num_counters_p.
  - [31:16] = overrun_o value at capture.
  - [width_p-1:32] = sequence number. It starts at 0, increments per accepted trigger and wraps modulo 2^(width_p−32).
- data_o = 0 when v_o = 0.
- Shadow is held stable for the whole stream. Changes on counters_i after capture are never visible in the stream.
- en_i does not gate streaming or start_i.

## Timing
- Reset values: v_o 0, data_o 0, last_o 0, busy_o 0, overrun_o 0. Sequence number 0, timer 0, state IDLE.
- Trigger at cycle t → header on data_o with v_o high at t+1.
- Minimum snapshot length is num_counters_p+1 cycles (36 at defaults) with ready_i held high.
- v_o, data_o and last_o are held stable while v_o & ~ready_i.
- Reset mid-stream: aborts the stream next cycle. All state returns to reset values and the partial snapshot is discarded.

## Structure
- Package ariane_profiler_pkg holds:
  - the sampler state enum;
  - a packed header struct {seq, overrun, count};
  - the constant num_stall_reasons = 35, shared with the issue profiler.
- Sub-module ariane_profiler_interval_timer contains the counter, the compare and the fire output.
- The shadow register file and the index mux stay in the top module.

## Test plan
- Single snapshot: interval_i=0, counters k=k*3, start_i pulse, ready_i=1 → header {seq 0, ovr 0, count 35}, then words 0,3,…,102; last_o on word 102; busy_o low afterward.
- Periodic: interval_i=100, en_i=1 → headers at cycles 101, 201, …; seq 0,1,2.
- en_i toggled 50% → firing period doubles.
- Backpressure: ready_i random 30% → every word held stable until accepted; values match the snapshot.
- Overrun: start_i pulsed at stream word 10 → stream unaffected, overrun_o=1, next header ovr field=1.
- 70000 overruns → overrun_o saturates at 65535.
- Back-to-back: start_i on the final handshake → next header at the following cycle with seq+1, no overrun.
- Counters changing every cycle during a stream → stream equals the values at the capture edge.
- Reset mid-BODY → v_o=0 next cycle; the next snapshot's seq is 0.
